bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ack_i before bus error (1..255).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  in  1  reset; synchronous and active-low.
REQ-004 f_adr_i  in  64  fetch-unit address.
REQ-005 f_size_i  in  2  fetch size; 00 means no request.
REQ-006 f_vpa_i  in  1  fetch-unit opcode-fetch qualifier.
REQ-007 f_ack_o  in/out: out  1  ack routed to fetch unit.
REQ-008 d_adr_i  in  64  load/store address.
REQ-009 d_size_i  in  2  load/store size; 00 means no request.
REQ-010 d_we_i  in  1  load/store write enable.
REQ-011 d_dat_i  in  16  load/store write data.
REQ-012 d_ack_o  out  1  ack routed to load/store unit.
REQ-013 adr_o, size_o, we_o, dat_o, vpa_o  out  64/2/1/16/1  external bus.
REQ-014 ack_i  in  1  external bus acknowledge; external dat_i goes directly to both units, not through this block.
REQ-015 berr_o  out  1  one-cycle bus-timeout pulse; berr_src_o  out  1  0=fetch, 1=data.

Function
REQ-016 States: IDLE, FETCH, DATA held in a registered grant; external bus outputs are combinational muxes of the owner's inputs.
REQ-017 IDLE: adr_o=0, size_o=00, we_o=0, dat_o=0, vpa_o=0, f_ack_o=d_ack_o=0.
REQ-018 FETCH: drive f_adr_i, f_size_i, f_vpa_i; we_o=0, dat_o=0; f_ack_o=ack_i, d_ack_o=0.
REQ-019 DATA: drive d_adr_i, d_size_i, d_we_i, d_dat_i; vpa_o=0; d_ack_o=ack_i, f_ack_o=0.
REQ-020 Request means size!=00; grant takes effect the cycle after the request is first seen (1-cycle latency from IDLE).
REQ-021 Owner keeps grant (bus lock) while its size stays nonzero, so a two-halfword fetch is never split.
REQ-022 When owner drops size to 00, next state is chosen by arbitration in that same edge (no idle bubble); IDLE only if no request.
REQ-023 Arbitration when both request: grant to the requester not granted last (last_owner bit); single requester always wins.
REQ-024 last_owner updates on each grant entry; size 11 is forwarded unmodified.

Reset
REQ-025 While reset_i=0 at a clock edge: state=IDLE, last_owner=DATA (fetch wins first contention), timeout counter=0, berr_o=0.
REQ-026 Reset mid-transfer drops grant immediately at that edge; outputs follow REQ-017 next cycle.

Configuration
REQ-027 Macro BUS_TIMEOUT_EN defined: 8-bit counter counts granted cycles with ack_i=0, clears on ack_i=1 or grant change; on reaching TIMEOUT_CYCLES, berr_o=1 and berr_src_o=owner for one cycle, grant forced to IDLE, owner sees no ack.
REQ-028 Macro undefined: no counter; berr_o and berr_src_o tied 0; grant never forced off.

Structure
REQ-029 Shared package bus_pkg holds state encoding (IDLE/FETCH/DATA), SIZE codes (00 none, 01 byte, 10 halfword), owner encoding.
REQ-030 Timeout counter is sub-module bus_watchdog, instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-031 Reset low 2 cycles, f_size_i=10, f_adr_i=FFFFFFFFFFFFFF00 -> after reset release, size_o=00 one cycle, then adr_o=...FF00, vpa_o=1.
REQ-032 Fetch holds size=10 across two acks (adr ...FF00 then ...FF02) while d_size_i=10 -> data not granted until f_size_i=00; next cycle adr_o=d_adr_i, we_o=d_we_i.
REQ-033 Both request from IDLE after reset -> FETCH first; after release with both still requesting -> DATA; then FETCH (alternation).
REQ-034 DATA owner, ack_i=1 -> d_ack_o=1, f_ack_o=0; dat_o=d_dat_i=1234h while d_we_i=1.
REQ-035 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, data granted, ack_i=0 -> berr_o=1, berr_src_o=1 at 4th waiting cycle; state IDLE next.
REQ-036 reset_i=0 during DATA transfer -> next cycle size_o=00, no acks, berr_o=0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared grant-state, size and owner encodings for the bus arbiter
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    function automatic logic is_req(input logic [1:0] size);
        return size != SIZE_NONE;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - fetch/data unit requests and shared external bus signals
interface bus_arbiter_if;

    logic [63:0] f_adr_i;
    logic [1:0]  f_size_i;
    logic        f_vpa_i;
    logic        f_ack_o;

    logic [63:0] d_adr_i;
    logic [1:0]  d_size_i;
    logic        d_we_i;
    logic [15:0] d_dat_i;
    logic        d_ack_o;

    logic [63:0] adr_o;
    logic [1:0]  size_o;
    logic        we_o;
    logic [15:0] dat_o;
    logic        vpa_o;
    logic        ack_i;

    logic        berr_o;
    logic        berr_src_o;

    // Arbiter side: owns the external bus and routes acks back to the units
    modport master (
        input  f_adr_i, f_size_i, f_vpa_i, d_adr_i, d_size_i, d_we_i, d_dat_i, ack_i,
        output f_ack_o, d_ack_o, adr_o, size_o, we_o, dat_o, vpa_o, berr_o, berr_src_o
    );

    // Environment side: the two requesting units and the external bus slave
    modport slave (
        output f_adr_i, f_size_i, f_vpa_i, d_adr_i, d_size_i, d_we_i, d_dat_i, ack_i,
        input  f_ack_o, d_ack_o, adr_o, size_o, we_o, dat_o, vpa_o, berr_o, berr_src_o
    );

endinterface

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - counts unacknowledged granted cycles and flags a bus timeout
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic active_i,
    input  logic ack_i,
    input  logic grant_change_i,
    output logic hit_o
);

    logic [7:0] wait_cnt;

    // The current cycle is the TIMEOUT_CYCLES-th one waiting without ack
    assign hit_o = active_i && !ack_i && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles; any ack, idle bus, owner change or timeout restarts
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wait_cnt <= 8'd0;
        end else if (!active_i || ack_i || grant_change_i || hit_o) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (fetch/data) bus arbiter with lock and alternating priority; optional timeout under BUS_TIMEOUT_EN
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    bus_arbiter_if.master bus
);

    state_e state;
    state_e state_nxt;
    state_e winner;
    owner_e last_owner;
    logic   f_req;
    logic   d_req;
    logic   timeout_hit;
    logic   grant_change;

    assign f_req        = is_req(bus.f_size_i);
    assign d_req        = is_req(bus.d_size_i);
    assign grant_change = (state_nxt != state);

    // Pick the next owner: the current owner holds the lock while it requests,
    // otherwise arbitrate in the same edge, favouring whoever was not granted last
    always_comb begin
        winner = ST_IDLE;
        if (f_req && d_req) begin
            winner = (last_owner == OWN_DATA) ? ST_FETCH : ST_DATA;
        end else if (f_req) begin
            winner = ST_FETCH;
        end else if (d_req) begin
            winner = ST_DATA;
        end

        state_nxt = winner;
        case (state)
            ST_FETCH: if (f_req) state_nxt = ST_FETCH;
            ST_DATA:  if (d_req) state_nxt = ST_DATA;
            default:  state_nxt = winner;
        endcase

        if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // Grant register and last-owner tracking for fair contention
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state      <= ST_IDLE;
            last_owner <= OWN_DATA;
        end else begin
            state <= state_nxt;
            if (grant_change && state_nxt != ST_IDLE) begin
                last_owner <= (state_nxt == ST_DATA) ? OWN_DATA : OWN_FETCH;
            end
        end
    end

    // External bus and ack routing follow the registered owner combinationally
    always_comb begin
        bus.adr_o   = 64'd0;
        bus.size_o  = SIZE_NONE;
        bus.we_o    = 1'b0;
        bus.dat_o   = 16'd0;
        bus.vpa_o   = 1'b0;
        bus.f_ack_o = 1'b0;
        bus.d_ack_o = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.adr_o   = bus.f_adr_i;
                bus.size_o  = bus.f_size_i;
                bus.vpa_o   = bus.f_vpa_i;
                bus.f_ack_o = bus.ack_i;
            end
            ST_DATA: begin
                bus.adr_o   = bus.d_adr_i;
                bus.size_o  = bus.d_size_i;
                bus.we_o    = bus.d_we_i;
                bus.dat_o   = bus.d_dat_i;
                bus.d_ack_o = bus.ack_i;
            end
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i          (clk_i),
        .resetn_i       (reset_i),
        .active_i       (state != ST_IDLE),
        .ack_i          (bus.ack_i),
        .grant_change_i (grant_change),
        .hit_o          (timeout_hit)
    );

    assign bus.berr_o     = timeout_hit;
    assign bus.berr_src_o = (state == ST_DATA);
`else
    // No watchdog: the comparison is never true for a legal timeout value
    assign timeout_hit    = (TIMEOUT_CYCLES < 0);
    assign bus.berr_o     = 1'b0;
    assign bus.berr_src_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (directed + randomized against a reference model)
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i   (clk),
        .reset_i (resetn),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = nobody, 1 = fetch unit, 2 = data unit
    int owner  = 0;
    int last   = 2;
    int waited = 0;
    bit exp_berr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] e_adr;
        logic [1:0]  e_size;
        logic        e_we, e_vpa, e_fack, e_dack;
        logic [15:0] e_dat;
        e_adr = '0; e_size = '0; e_we = 0; e_vpa = 0; e_fack = 0; e_dack = 0; e_dat = '0;
        if (owner == 1) begin
            e_adr = bif.f_adr_i; e_size = bif.f_size_i; e_vpa = bif.f_vpa_i; e_fack = bif.ack_i;
        end else if (owner == 2) begin
            e_adr = bif.d_adr_i; e_size = bif.d_size_i; e_we = bif.d_we_i;
            e_dat = bif.d_dat_i; e_dack = bif.ack_i;
        end
        exp_berr = WD && owner != 0 && !bif.ack_i && (waited + 1 == TO);
        chk("m_adr", bif.adr_o, e_adr);
        chk("m_size", 64'(bif.size_o), 64'(e_size));
        chk("m_we", 64'(bif.we_o), 64'(e_we));
        chk("m_dat", 64'(bif.dat_o), 64'(e_dat));
        chk("m_vpa", 64'(bif.vpa_o), 64'(e_vpa));
        chk("m_fack", 64'(bif.f_ack_o), 64'(e_fack));
        chk("m_dack", 64'(bif.d_ack_o), 64'(e_dack));
        chk("m_berr", 64'(bif.berr_o), 64'(exp_berr));
        if (exp_berr) chk("m_berr_src", 64'(bif.berr_src_o), 64'(owner == 2));
    endtask

    task automatic update_model();
        bit fr, dr;
        int nxt;
        fr = bif.f_size_i != 2'b00;
        dr = bif.d_size_i != 2'b00;
        if (!resetn) begin
            owner = 0; last = 2; waited = 0;
        end else if (exp_berr) begin
            owner = 0; waited = 0;
        end else begin
            if (owner == 1 && fr)      nxt = 1;
            else if (owner == 2 && dr) nxt = 2;
            else if (fr && dr)         nxt = (last == 1) ? 2 : 1;
            else if (fr)               nxt = 1;
            else if (dr)               nxt = 2;
            else                       nxt = 0;
            if (nxt != owner && nxt != 0) last = nxt;
            waited = (owner != 0 && nxt == owner && !bif.ack_i) ? waited + 1 : 0;
            owner = nxt;
        end
        exp_berr = 1'b0;
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        bif.f_adr_i = '0; bif.f_size_i = '0; bif.f_vpa_i = 0;
        bif.d_adr_i = '0; bif.d_size_i = '0; bif.d_we_i = 0; bif.d_dat_i = '0;
        bif.ack_i = 0;
        exp_berr = 1'b0;
        @(posedge clk);
        update_model();
        @(negedge clk);

        // Reset held two edges with a fetch pending, then one idle cycle
        bif.f_size_i = 2'b10; bif.f_adr_i = 64'hFFFF_FFFF_FFFF_FF00; bif.f_vpa_i = 1;
        tick();
        resetn = 1'b1;
        #1 chk("rst_idle_size", 64'(bif.size_o), 64'd0);
        tick();
        #1 chk("fetch_adr", bif.adr_o, 64'hFFFF_FFFF_FFFF_FF00);
        chk("fetch_vpa", 64'(bif.vpa_o), 64'd1);

        // Fetch lock across two acks while data waits
        bif.d_size_i = 2'b10; bif.d_adr_i = 64'h0000_0000_1000_0040; bif.d_we_i = 1; bif.d_dat_i = 16'hABCD;
        bif.ack_i = 1;
        #1 chk("lock_fack1", 64'(bif.f_ack_o), 64'd1);
        chk("lock_dack1", 64'(bif.d_ack_o), 64'd0);
        tick();
        bif.f_adr_i = 64'hFFFF_FFFF_FFFF_FF02;
        #1 chk("lock_adr2", bif.adr_o, 64'hFFFF_FFFF_FFFF_FF02);
        chk("lock_fack2", 64'(bif.f_ack_o), 64'd1);
        tick();
        bif.ack_i = 0; bif.f_size_i = 2'b00;
        #1 chk("release_adr", bif.adr_o, 64'hFFFF_FFFF_FFFF_FF02);
        tick();
        #1 chk("data_adr", bif.adr_o, 64'h0000_0000_1000_0040);
        chk("data_we", 64'(bif.we_o), 64'd1);

        // Data owner write with ack
        bif.ack_i = 1; bif.d_dat_i = 16'h1234;
        #1 chk("data_dack", 64'(bif.d_ack_o), 64'd1);
        chk("data_fack", 64'(bif.f_ack_o), 64'd0);
        chk("data_dat", 64'(bif.dat_o), 64'h1234);
        tick();

        // Reset during a data transfer drops the grant at that edge
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1 chk("rst_mid_size", 64'(bif.size_o), 64'd0);
        chk("rst_mid_dack", 64'(bif.d_ack_o), 64'd0);
        chk("rst_mid_fack", 64'(bif.f_ack_o), 64'd0);
        chk("rst_mid_berr", 64'(bif.berr_o), 64'd0);
        tick();

        // Contention after reset: fetch first, then data, then fetch
        resetn = 1'b0; bif.ack_i = 0;
        bif.f_size_i = 2'b10; bif.f_adr_i = 64'h0000_0000_0000_2000;
        bif.d_size_i = 2'b01; bif.d_adr_i = 64'h0000_0000_0000_3000;
        tick();
        resetn = 1'b1;
        tick();
        #1 chk("alt_fetch_first", bif.adr_o, 64'h0000_0000_0000_2000);
        bif.f_size_i = 2'b00;
        tick();
        #1 chk("alt_data_adr", bif.adr_o, 64'h0000_0000_0000_3000);
        chk("alt_data_size", 64'(bif.size_o), 64'd1);
        bif.f_size_i = 2'b11; bif.d_size_i = 2'b00;
        tick();
        #1 chk("alt_fetch_size11", 64'(bif.size_o), 64'd3);

`ifdef BUS_TIMEOUT_EN
        // Data granted with no ack: error on the fourth waiting cycle
        resetn = 1'b0; bif.f_size_i = 2'b00; bif.d_size_i = 2'b01; bif.ack_i = 0;
        tick();
        resetn = 1'b1;
        tick();
        for (int i = 1; i < TO; i++) begin
            #1 chk("to_wait_berr", 64'(bif.berr_o), 64'd0);
            tick();
        end
        #1 chk("to_berr", 64'(bif.berr_o), 64'd1);
        chk("to_berr_src", 64'(bif.berr_src_o), 64'd1);
        tick();
        #1 chk("to_idle_size", 64'(bif.size_o), 64'd0);
        chk("to_idle_dack", 64'(bif.d_ack_o), 64'd0);
        tick();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 49) != 0);
            if (bif.f_size_i == 2'b00 || $urandom_range(0, 3) == 0) bif.f_size_i = 2'($urandom_range(0, 3));
            if (bif.d_size_i == 2'b00 || $urandom_range(0, 3) == 0) bif.d_size_i = 2'($urandom_range(0, 3));
            bif.f_adr_i = {$urandom, $urandom};
            bif.d_adr_i = {$urandom, $urandom};
            bif.f_vpa_i = 1'($urandom);
            bif.d_we_i  = 1'($urandom);
            bif.d_dat_i = 16'($urandom);
            bif.ack_i   = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
